// File: rtl/display_arbiter_ctrl_if.sv
// Request/ack handshake and display outputs shared by the two display sources,
// the arbiter and the 7-segment decoders.
interface display_arbiter_ctrl_if;
  logic        cpu_req;
  logic [31:0] cpu_data;
  logic        cpu_ack;
  logic        dbg_req;
  logic [31:0] dbg_data;
  logic        dbg_ack;
  logic        busy;
  logic        done;
  logic        src;
  logic [3:0]  digit0;
  logic [3:0]  digit1;
  logic [3:0]  digit2;
  logic [3:0]  digit3;
  logic [3:0]  digit4;

  modport master (
    output cpu_req, cpu_data, dbg_req, dbg_data,
    input  cpu_ack, dbg_ack, busy, done, src,
    input  digit0, digit1, digit2, digit3, digit4
  );

  modport slave (
    input  cpu_req, cpu_data, dbg_req, dbg_data,
    output cpu_ack, dbg_ack, busy, done, src,
    output digit0, digit1, digit2, digit3, digit4
  );
endinterface

// File: rtl/display_arbiter_ctrl.sv
// Arbitrates CPU and debug display requests and converts the granted 32-bit
// value to five BCD digits with a serial double-dabble, or shows 'E' on overflow.
module display_arbiter_ctrl #(
  parameter logic [31:0] MAX_VALUE = 32'd99999,
  parameter int unsigned CONV_BITS = 17
) (
  input logic                   clk,
  input logic                   rst_n,
  display_arbiter_ctrl_if.slave bus
);

  localparam int unsigned BCD_W     = 20;
  localparam int unsigned NIBBLES   = BCD_W / 4;
  localparam int unsigned CNT_W     = $clog2(CONV_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(CONV_BITS - 1);
  localparam logic [3:0] DIGIT_ERR   = 4'd14;
  localparam logic [3:0] DIGIT_BLANK = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [31:0]          cap;
  logic [CONV_BITS-1:0] sh;
  logic [BCD_W-1:0]     bcd;
  logic [CNT_W-1:0]     cnt;
  logic                 ack_pend;
  logic                 gnt_src;
  logic                 last_dbg;

  logic                 req_any_c;
  logic                 gnt_src_c;
  logic [31:0]          gnt_data_c;
  logic [BCD_W-1:0]     bcd_adj_c;

  // Ties go to the source that did not win last time.
  assign req_any_c  = bus.cpu_req | bus.dbg_req;
  assign gnt_src_c  = (bus.cpu_req && bus.dbg_req) ? ~last_dbg : bus.dbg_req;
  assign gnt_data_c = gnt_src_c ? bus.dbg_data : bus.cpu_data;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj_c = bcd;
    for (int i = 0; i < NIBBLES; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        bcd_adj_c[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cap         <= '0;
      sh          <= '0;
      bcd         <= '0;
      cnt         <= '0;
      ack_pend    <= 1'b0;
      gnt_src     <= 1'b0;
      last_dbg    <= 1'b1;
      bus.cpu_ack <= 1'b0;
      bus.dbg_ack <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.src     <= 1'b0;
      bus.digit0  <= DIGIT_BLANK;
      bus.digit1  <= DIGIT_BLANK;
      bus.digit2  <= DIGIT_BLANK;
      bus.digit3  <= DIGIT_BLANK;
      bus.digit4  <= DIGIT_BLANK;
    end else begin
      // The ack trails the capture edge by one cycle.
      bus.cpu_ack <= ack_pend & ~gnt_src;
      bus.dbg_ack <= ack_pend &  gnt_src;
      ack_pend    <= 1'b0;
      bus.done    <= 1'b0;
      bus.busy    <= (state != IDLE);

      unique case (state)
        IDLE: begin
          if (req_any_c) begin
            state    <= CONV;
            cap      <= gnt_data_c;
            sh       <= gnt_data_c[CONV_BITS-1:0];
            bcd      <= '0;
            cnt      <= '0;
            ack_pend <= 1'b1;
            gnt_src  <= gnt_src_c;
            last_dbg <= gnt_src_c;
          end
        end

        CONV: begin
          if (cnt == '0 && cap > MAX_VALUE) begin
            state      <= IDLE;
            bus.done   <= 1'b1;
            bus.src    <= gnt_src;
            bus.digit0 <= DIGIT_ERR;
            bus.digit1 <= DIGIT_ERR;
            bus.digit2 <= DIGIT_ERR;
            bus.digit3 <= DIGIT_ERR;
            bus.digit4 <= DIGIT_ERR;
          end else begin
            bcd <= {bcd_adj_c[BCD_W-2:0], sh[CONV_BITS-1]};
            sh  <= {sh[CONV_BITS-2:0], 1'b0};
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_STEP) begin
              state <= DONE;
            end
          end
        end

        DONE: begin
          state      <= IDLE;
          bus.done   <= 1'b1;
          bus.src    <= gnt_src;
          bus.digit0 <= bcd[3:0];
          bus.digit1 <= bcd[7:4];
          bus.digit2 <= bcd[11:8];
          bus.digit3 <= bcd[15:12];
          bus.digit4 <= bcd[19:16];
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_arbiter_ctrl.sv
// Directed bench for display_arbiter_ctrl: a scoreboard of expected displays is
// filled at each ack and drained by a monitor on every done pulse.
`timescale 1ns/1ps
module tb_display_arbiter_ctrl;

  typedef struct packed {
    logic [19:0] dig;
    logic        src;
    logic [31:0] cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int          n_vec;
  int          n_err;
  int          cyc;
  exp_t        sb[$];
  exp_t        e;
  logic [20:0] prev;
  logic [19:0] dig;

  display_arbiter_ctrl_if bus ();

  display_arbiter_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign dig = {bus.digit4, bus.digit3, bus.digit2, bus.digit1, bus.digit0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain decimal digits by division, 'E' code above 99999.
  function automatic logic [19:0] exp_digits(input logic [31:0] val);
    logic [19:0] r;
    logic [31:0] v;
    r = '0;
    v = val;
    if (val > 32'd99999) return 20'hEEEEE;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic push(input logic s, input logic [31:0] d, input int ack_cyc);
    exp_t x;
    x.dig = exp_digits(d);
    x.src = s;
    x.cyc = 32'(ack_cyc + ((d > 32'd99999) ? 0 : 17));
    sb.push_back(x);
  endtask

  // Monitor: pops on done, otherwise the display must not move.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      prev = {bus.src, dig};
    end else begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("digits", 32'(dig), 32'(e.dig));
          chk("src", 32'(bus.src), 32'(e.src));
          chk("done_cycle", 32'(cyc), e.cyc);
          chk("busy_at_done", 32'(bus.busy), 32'd1);
        end
      end else begin
        chk("hold_stable", 32'(prev), 32'({bus.src, dig}));
      end
      prev = {bus.src, dig};
    end
  end

  task automatic wait_ack(input logic s, output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(s ? bus.dbg_ack : bus.cpu_ack) && c < 60);
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (sb.size() != 0 && c < 60) begin
      @(negedge clk);
      c++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_digits"}, 32'(dig), 32'hFFFFF);
    chk({tag, "_ctrl"}, 32'({bus.src, bus.busy, bus.done, bus.cpu_ack, bus.dbg_ack}), 32'd0);
  endtask

  task automatic run(input logic s, input logic [31:0] d);
    int c;
    if (s) begin bus.dbg_data = d; bus.dbg_req = 1'b1; end
    else   begin bus.cpu_data = d; bus.cpu_req = 1'b1; end
    wait_ack(s, c);
    chk("ack_latency", 32'(c), 32'd2);
    chk("busy_at_ack", 32'(bus.busy), 32'd1);
    push(s, d, cyc);
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    wait_drain();
  endtask

  // Both sources held: grants must alternate, one every 19 cycles.
  task automatic tie(input int n);
    int   c;
    int   last_ack;
    logic want;
    bus.cpu_data = 32'd7;
    bus.dbg_data = 32'd42;
    bus.cpu_req  = 1'b1;
    bus.dbg_req  = 1'b1;
    want     = 1'b0;
    last_ack = 0;
    for (int i = 0; i < n; i++) begin
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (!(bus.cpu_ack || bus.dbg_ack) && c < 60);
      chk("tie_winner", 32'({bus.cpu_ack, bus.dbg_ack}), want ? 32'd1 : 32'd2);
      if (i == 0) chk("tie_latency", 32'(c), 32'd2);
      else        chk("tie_gap", 32'(cyc - last_ack), 32'd19);
      push(want, want ? 32'd42 : 32'd7, cyc);
      last_ack = cyc;
      want = ~want;
    end
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    wait_drain();
  endtask

  // A debug request raised mid-conversion waits for the edge after done.
  task automatic mid_conv_request();
    int c;
    int ack_c;
    bus.cpu_data = 32'd12345;
    bus.cpu_req  = 1'b1;
    wait_ack(1'b0, c);
    chk("mid_cpu_ack_latency", 32'(c), 32'd2);
    ack_c = cyc;
    push(1'b0, 32'd12345, cyc);
    bus.cpu_req = 1'b0;
    repeat (5) @(negedge clk);
    bus.dbg_data = 32'd321;
    bus.dbg_req  = 1'b1;
    wait_ack(1'b1, c);
    chk("mid_dbg_grant_cycle", 32'(cyc - ack_c), 32'd19);
    push(1'b1, 32'd321, cyc);
    bus.dbg_req = 1'b0;
    wait_drain();
  endtask

  // Reset at T+9 of a conversion: no done, blank digits, then a clean re-grant.
  task automatic reset_mid_conv();
    int c;
    bus.cpu_data = 32'd54321;
    bus.cpu_req  = 1'b1;
    wait_ack(1'b0, c);
    chk("rmc_ack_latency", 32'(c), 32'd2);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rmc_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ack(1'b0, c);
    chk("rmc_regrant_latency", 32'(c), 32'd2);
    push(1'b0, 32'd54321, cyc);
    bus.cpu_req = 1'b0;
    wait_drain();
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    bus.cpu_req  = 1'b0;
    bus.dbg_req  = 1'b0;
    bus.cpu_data = '0;
    bus.dbg_data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    tie(4);
    run(1'b0, 32'd12345);
    run(1'b1, 32'd99999);
    run(1'b1, 32'd100000);
    run(1'b0, 32'd0);
    run(1'b0, 32'hFFFFFFFF);
    run(1'b1, 32'd908);
    mid_conv_request();
    reset_mid_conv();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
